// File: rtl/cdc_arb_pkg.sv
// Shared types and width helpers for the CDC channel arbiter.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } t_arb_state;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last-served index, with wrap.
module rr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int unsigned G_REQ = 4,
  parameter int unsigned IW    = idx_width(G_REQ)
) (
  input  logic [G_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [G_REQ-1:0] grant_c,
  output logic [IW-1:0]    idx_c,
  output logic             any_c
);

  logic [IW-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= G_REQ; i++) begin
      cand = IW'((32'(last) + i) % G_REQ);
      if (!any_c && req[cand]) begin
        grant_c[cand] = 1'b1;
        idx_c         = cand;
        any_c         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdc_channel_arbiter.sv
// Domain-A controller sharing one pulse/data CDC channel among G_REQ requesters:
// round-robin accept, one-cycle launch pulse, then a fixed G_HOLD-cycle data guard window.
module cdc_channel_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int unsigned G_REQ   = 4,
  parameter int unsigned G_WIDTH = 4,
  parameter int unsigned G_HOLD  = 8
) (
  input  logic                       i_clk_A,
  input  logic                       i_rst_A,
  input  logic [G_REQ-1:0]           i_valid,
  input  logic [G_REQ*G_WIDTH-1:0]   i_data,
  output logic [G_REQ-1:0]           o_ready,
  output logic                       o_pulse_A,
  output logic [G_WIDTH-1:0]         o_data_A,
  output logic                       o_busy,
  output logic [$clog2(G_REQ)-1:0]   o_grant_id
);

  localparam int unsigned IW = idx_width(G_REQ);
  localparam int unsigned CW = cnt_width(G_HOLD);

  t_arb_state         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               accept;
  logic [G_REQ-1:0]   grant_c;
  logic [IW-1:0]      idx_c;
  logic               any_c;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      gid_q;
  logic [G_WIDTH-1:0] data_q;
  logic               pulse_q;
  logic               busy_q;

  rr_arbiter #(
    .G_REQ (G_REQ),
    .IW    (IW)
  ) u_rr (
    .req     (i_valid),
    .last    (last_q),
    .grant_c (grant_c),
    .idx_c   (idx_c),
    .any_c   (any_c)
  );

  // Grants are only offered while idle and out of reset.
  assign o_ready = (state_q == IDLE && !i_rst_A) ? grant_c : '0;

  always_ff @(posedge i_clk_A) begin
    if (i_rst_A) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_c && |(i_valid & o_ready)) begin
          accept  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        // Counter tops out at G_HOLD, which fits CW bits, so it never wraps.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(G_HOLD - 1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Launch data, pointer and status registers.
  always_ff @(posedge i_clk_A) begin
    if (i_rst_A) begin
      data_q  <= '0;
      last_q  <= IW'(G_REQ - 1);
      gid_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pulse_q <= accept;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        data_q <= i_data[32'(idx_c)*G_WIDTH +: G_WIDTH];
        last_q <= idx_c;
        gid_q  <= idx_c;
      end
    end
  end

  assign o_pulse_A  = pulse_q;
  assign o_data_A   = data_q;
  assign o_busy     = busy_q;
  assign o_grant_id = gid_q;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Bench for cdc_channel_arbiter: a G_HOLD=8 and a G_HOLD=1 instance share inputs and are checked
// against a timeline model, plus a vector table and directed multi-cycle sequences.
module tb_cdc_channel_arbiter;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [15:0] data;

  logic [3:0] ready8, ready1;
  logic       pulse8, pulse1, busy8, busy1;
  logic [3:0] dout8, dout1;
  logic [1:0] gid8, gid1;

  always #5 clk = ~clk;

  cdc_channel_arbiter #(.G_REQ(4), .G_WIDTH(4), .G_HOLD(8)) u_dut8 (
    .i_clk_A(clk), .i_rst_A(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready8), .o_pulse_A(pulse8), .o_data_A(dout8), .o_busy(busy8), .o_grant_id(gid8)
  );

  cdc_channel_arbiter #(.G_REQ(4), .G_WIDTH(4), .G_HOLD(1)) u_dut1 (
    .i_clk_A(clk), .i_rst_A(rst), .i_valid(valid), .i_data(data),
    .o_ready(ready1), .o_pulse_A(pulse1), .o_data_A(dout1), .o_busy(busy1), .o_grant_id(gid1)
  );

  // Model: last accept cycle, first cycle a new accept is allowed, and the latched word.
  typedef struct {
    int last;
    int acc;
    int freec;
    int data;
    int gid;
    int hold;
  } mdl_t;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic [3:0]  ready;
    logic        pulse;
    logic        busy;
    logic [3:0]  dout;
    logic [1:0]  gid;
  } vec_t;

  mdl_t       m[2];
  logic [3:0] exp_ready[2];
  int         n;
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       tbl[12];
  int         pcyc[$];
  int         pgid[$];
  int         pdat[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic logic [3:0] pick(input int last, input logic [3:0] v);
    int c = last;
    for (int k = 0; k < N; k++) begin
      c = (c + 1) % N;
      if (v[c]) return 4'(1 << c);
    end
    return 4'b0;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] rdy, input logic p,
                              input logic b, input logic [3:0] dq, input logic [1:0] g);
    vec_t t;
    t.v = v; t.d = 16'h0A05; t.ready = rdy; t.pulse = p; t.busy = b; t.dout = dq; t.gid = g;
    return t;
  endfunction

  task automatic model_reset(input int k);
    m[k].last  = N - 1;
    m[k].acc   = -100;
    m[k].freec = n + 1;
    m[k].data  = 0;
    m[k].gid   = 0;
  endtask

  // Drive one cycle of inputs and check both instances against the model at the falling edge.
  task automatic apply(input logic [3:0] v, input logic [15:0] d, input logic r);
    logic ep, eb;
    valid = v; data = d; rst = r;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      exp_ready[k] = r ? 4'b0 : ((n >= m[k].freec) ? pick(m[k].last, v) : 4'b0);
    ep = (n == m[0].acc + 1);
    eb = (n >= m[0].acc + 1) && (n <= m[0].acc + m[0].hold + 1);
    chk("ready_h8", 32'(ready8), 32'(exp_ready[0]));
    chk("pulse_h8", 32'(pulse8), 32'(ep));
    chk("busy_h8",  32'(busy8),  32'(eb));
    chk("data_h8",  32'(dout8),  32'(m[0].data));
    chk("gid_h8",   32'(gid8),   32'(m[0].gid));
    ep = (n == m[1].acc + 1);
    eb = (n >= m[1].acc + 1) && (n <= m[1].acc + m[1].hold + 1);
    chk("ready_h1", 32'(ready1), 32'(exp_ready[1]));
    chk("pulse_h1", 32'(pulse1), 32'(ep));
    chk("busy_h1",  32'(busy1),  32'(eb));
    chk("data_h1",  32'(dout1),  32'(m[1].data));
    chk("gid_h1",   32'(gid1),   32'(m[1].gid));
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        model_reset(k);
      end else if (exp_ready[k] != 4'b0) begin
        for (int c = 0; c < N; c++) begin
          if (exp_ready[k][c]) begin
            m[k].acc   = n;
            m[k].freec = n + m[k].hold + 2;
            m[k].data  = int'((data >> (4 * c)) & 16'hF);
            m[k].last  = c;
            m[k].gid   = c;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    m[0].hold = 8;
    m[1].hold = 1;
    rst = 1'b1; valid = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    n = 0;
    model_reset(0);
    model_reset(1);
    m[0].freec = 0;
    m[1].freec = 0;

    // Single request from requester 2, then a request raised during HOLD.
    tbl[0]  = mk(4'b0100, 4'b0100, 1'b0, 1'b0, 4'h0, 2'd0);
    tbl[1]  = mk(4'b0000, 4'b0000, 1'b1, 1'b1, 4'hA, 2'd2);
    for (int i = 2; i < 5; i++)  tbl[i] = mk(4'b0000, 4'b0000, 1'b0, 1'b1, 4'hA, 2'd2);
    for (int i = 5; i < 10; i++) tbl[i] = mk(4'b0001, 4'b0000, 1'b0, 1'b1, 4'hA, 2'd2);
    tbl[10] = mk(4'b0001, 4'b0001, 1'b0, 1'b0, 4'hA, 2'd2);
    tbl[11] = mk(4'b0001, 4'b0000, 1'b1, 1'b1, 4'h5, 2'd0);
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_ready", i), 32'(ready8), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_pulse", i), 32'(pulse8), 32'(tbl[i].pulse));
      chk($sformatf("tbl%0d_busy", i),  32'(busy8),  32'(tbl[i].busy));
      chk($sformatf("tbl%0d_data", i),  32'(dout8),  32'(tbl[i].dout));
      chk($sformatf("tbl%0d_gid", i),   32'(gid8),   32'(tbl[i].gid));
      advance();
    end

    // All requesters continuously valid with words 1..4.
    apply(4'b0000, 16'h0000, 1'b1);
    advance();
    for (int i = 0; i < 45; i++) begin
      apply(4'hF, 16'h4321, 1'b0);
      if (pulse8) begin
        pcyc.push_back(n);
        pgid.push_back(int'(gid8));
        pdat.push_back(int'(dout8));
      end
      advance();
    end
    chk("rr_pulse_count", 32'(pcyc.size()), 32'd5);
    for (int i = 0; i < pcyc.size(); i++) begin
      chk($sformatf("rr_gid%0d", i),  32'(pgid[i]), 32'(i % 4));
      chk($sformatf("rr_word%0d", i), 32'(pdat[i]), 32'(i % 4 + 1));
      if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(pcyc[i] - pcyc[i-1]), 32'd10);
    end

    // Reset in the third HOLD cycle abandons the word; requester 0 then wins over 3.
    apply(4'b0000, 16'h3A05, 1'b1); advance();
    apply(4'b0100, 16'h3A05, 1'b0); advance();
    apply(4'b0000, 16'h3A05, 1'b0); advance();
    apply(4'b0000, 16'h3A05, 1'b0); advance();
    apply(4'b0000, 16'h3A05, 1'b0); advance();
    apply(4'b1001, 16'h3A05, 1'b1);
    chk("mid_busy_before", 32'(busy8), 32'd1);
    advance();
    apply(4'b1001, 16'h3A05, 1'b0);
    chk("rst_data", 32'(dout8),  32'd0);
    chk("rst_busy", 32'(busy8),  32'd0);
    chk("rst_pulse", 32'(pulse8), 32'd0);
    chk("rst_ready", 32'(ready8), 32'b0001);
    advance();
    apply(4'b1001, 16'h3A05, 1'b0);
    chk("post_rst_gid", 32'(gid8), 32'd0);
    chk("post_rst_word", 32'(dout8), 32'h5);
    advance();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      apply(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 63) == 0));
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdc_channel_arbiter.md
Name: cdc_channel_arbiter

Overview:
- Source-domain (clock A) controller that shares one recirculation-mux CDC channel between G_REQ requesters.
- Accepts words through per-requester valid/ready handshakes and selects a winner round-robin.
- Drives the channel's pulse and data inputs: a one-cycle pulse, then data held stable for a guard window.
- The channel has no acknowledge back to domain A, so the guard window is a fixed cycle count, G_HOLD.

Parameters:
- G_REQ, 4, number of requesters; must be ≥2.
- G_WIDTH, 4, data word width; must match the channel's G_WIDTH.
- G_HOLD, 8, domain-A cycles o_data_A is held after the pulse cycle; must be ≥1. Integrator sizes it as ≥ (G_STAGES+3)·ceil(T_B/T_A).

Ports:
- i_clk_A  in  1  domain-A clock; the block's only clock.
- i_rst_A  in  1  reset; synchronous, active-high.
- i_valid  in  G_REQ  per-requester request; bit r belongs to requester r.
- i_data  in  G_REQ*G_WIDTH  flattened words; requester r occupies bits [r*G_WIDTH +: G_WIDTH].
- o_ready  out  G_REQ  one-hot or zero grant; combinational.
- o_pulse_A  out  1  launch pulse to channel i_pulse_A.
- o_data_A  out  G_WIDTH  registered word to channel i_data_A.
- o_busy  out  1  high while state ≠ IDLE.
- o_grant_id  out  $clog2(G_REQ)  index of the most recently accepted requester.

Behaviour:
- Reset values (synchronous, i_rst_A=1):
  - state=IDLE, hold counter=0, o_pulse_A=0, o_data_A=0, o_grant_id=0.
  - RR pointer last=G_REQ-1, so requester 0 has first priority.
  - o_ready is forced to all 0 while i_rst_A=1.
- FSM states: IDLE, LAUNCH, HOLD.
- IDLE:
  - o_ready is one-hot of the first set i_valid bit, searching (last+1) mod G_REQ upward with wrap.
  - If no i_valid bit is set, o_ready=0.
  - Transfer occurs on the edge where i_valid[r]&o_ready[r]. On that edge: o_data_A<=i_data[r], last<=r, o_grant_id<=r, state<=LAUNCH.
- LAUNCH:
  - o_pulse_A=1 for exactly this one cycle (registered, no combinational path from i_valid). o_ready=0.
  - Next state: HOLD, with counter<=0.
- HOLD:
  - o_pulse_A=0, o_ready=0; counter increments each cycle.
  - When counter==G_HOLD-1, state<=IDLE.
  - Counter width is $clog2(G_HOLD+1); it never wraps.
- Latency and throughput:
  - Handshake edge at cycle t → o_pulse_A high during cycle t+1.
  - o_data_A is valid from t+1 and stable through at least t+1+G_HOLD.
  - Earliest next handshake is the edge ending cycle t+G_HOLD+2.
  - Sustained throughput is one word per G_HOLD+2 cycles.
- o_data_A keeps its last value in IDLE; it changes only on an accepted transfer.
- Requesters must hold i_valid and i_data until accepted. i_valid must not depend on o_ready.
- A requester dropping i_valid before acceptance is legal; it is simply not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. The others wait, without starvation: each is served within G_REQ transfers.
- A single continuously valid requester is re-granted every G_HOLD+2 cycles; its own pointer position does not block it.
- i_valid asserted during LAUNCH/HOLD is ignored until IDLE. No request is lost provided the requester holds i_valid.
- Reset mid-LAUNCH/HOLD: the in-flight word is abandoned and o_data_A returns to 0 next cycle. The downstream channel must be reset alongside.
- o_busy = (state≠IDLE), registered-equivalent (decoded from the state register).

Decomposition:
- Package cdc_arb_pkg: state enum t_arb_state {IDLE, LAUNCH, HOLD}, and width helper functions for the grant index and counter.
- Sub-module rr_arbiter (parameter G_REQ), purely combinational:
  - Inputs: request vector, last pointer.
  - Outputs: one-hot grant, encoded index, any-request flag.
- The top level holds the FSM, counter, data register and pointer.

Test Plan:
- Single request: G_HOLD=8, i_valid=4'b0100, i_data[2]=4'hA → o_ready=4'b0100 in one cycle; o_pulse_A high the next cycle only; o_data_A=4'hA; o_busy high 9 cycles; o_grant_id=2.
- All requesters continuously valid, words 1,2,3,4 → grant order 0,1,2,3,0… with pulses exactly 10 cycles apart.
- Request raised during HOLD → no o_ready until IDLE; granted on the first IDLE cycle; no pulse while busy.
- Reset asserted in 3rd HOLD cycle → next cycle o_data_A=0, o_busy=0, o_pulse_A=0; the first grant after reset goes to requester 0 even if 0 and 3 are both valid.
- G_HOLD=1 boundary → handshakes exactly 3 cycles apart; o_data_A changes only on grant edges.
- Integration with recirculation_mux (G_STAGES=2, clock B 3× slower, G_HOLD=15) → o_data_B sequence equals the accepted word sequence, with no corrupted or skipped word.
